// File: rtl/fadd_pkg.sv
// Shared p_float definitions and widths for the fadd pipeline.
package fadd_pkg;

  localparam int unsigned EXP_W    = 8;
  localparam int unsigned FRAC_W   = 11;
  localparam int unsigned GRS_W    = 3;
  localparam int unsigned FADD_LAT = 5;

  localparam int unsigned E_W   = EXP_W + 1;
  localparam int unsigned M_W   = FRAC_W + 1;
  localparam int unsigned D_W   = EXP_W + 2;
  localparam int unsigned AL_W  = FRAC_W + 4;
  localparam int unsigned SUM_W = FRAC_W + 5;
  localparam int unsigned LZ_W  = $clog2(SUM_W + 1);

  // exp is two's-complement unbiased; frac[M_W-1] is the hidden bit
  typedef struct packed {
    logic           sign;
    logic [E_W-1:0] exp;
    logic [M_W-1:0] frac;
  } p_float;

endpackage

// File: rtl/fadd_lzc.sv
// Combinational leading-zero counter with all-zero flag.
module fadd_lzc
  import fadd_pkg::*;
#(
  parameter int unsigned W  = SUM_W,
  parameter int unsigned CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  x,
  output logic [CW-1:0] lz_c,
  output logic          zero_c
);

  // Ascending scan: the highest set bit is the last one to assign
  always_comb begin
    lz_c   = CW'(W);
    zero_c = ~|x;
    for (int i = 0; i < W; i++) begin
      if (x[i]) lz_c = CW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/fadd.sv
// Five-stage p_float adder/subtractor, round to nearest even.
// Optional c_zero output enabled by defining FADD_ZERO_FLAG_EN.
module fadd
  import fadd_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   in_valid,
  input  p_float a,
  input  p_float b,
  input  logic   sub,
  output logic   out_valid,
`ifdef FADD_ZERO_FLAG_EN
  output logic   c_zero,
`endif
  output p_float c
);

  logic s1_v, s2_v, s3_v, s4_v;

  logic             s1_sign, s1_eff_sub;
  logic [E_W-1:0]   s1_exp;
  logic [M_W-1:0]   s1_big_frac, s1_small_frac;
  logic [D_W-1:0]   s1_d;

  logic             s2_sign, s2_eff_sub;
  logic [E_W-1:0]   s2_exp;
  logic [M_W-1:0]   s2_big_frac;
  logic [AL_W-1:0]  s2_al;

  logic             s3_sign;
  logic [E_W-1:0]   s3_exp;
  logic [SUM_W-1:0] s3_sum;

  logic             s4_sign, s4_zero;
  logic [E_W-1:0]   s4_exp;
  logic [AL_W-1:0]  s4_mant;

  // S1: order by magnitude, a wins ties
  logic           a_big_c, sign_c, eff_sub_c;
  logic [E_W-1:0] big_exp_c, small_exp_c;
  logic [M_W-1:0] big_frac_c, small_frac_c;
  logic [D_W-1:0] d_c;

  always_comb begin
    a_big_c = 1'b1;
    if ($signed(b.exp) > $signed(a.exp)) a_big_c = 1'b0;
    else if ((b.exp == a.exp) && (b.frac > a.frac)) a_big_c = 1'b0;
    eff_sub_c    = a.sign ^ b.sign ^ sub;
    sign_c       = a_big_c ? a.sign : (b.sign ^ sub);
    big_exp_c    = a_big_c ? a.exp  : b.exp;
    small_exp_c  = a_big_c ? b.exp  : a.exp;
    big_frac_c   = a_big_c ? a.frac : b.frac;
    small_frac_c = a_big_c ? b.frac : a.frac;
    d_c          = D_W'($signed(big_exp_c)) - D_W'($signed(small_exp_c));
  end

  // S2: align small operand, folding shifted-out bits into sticky
  logic [AL_W-1:0] small_ext_c, shifted_c, mask_c, al_c;

  always_comb begin
    small_ext_c = {s1_small_frac, GRS_W'(0)};
    mask_c      = ~({AL_W{1'b1}} << s1_d);
    shifted_c   = small_ext_c >> s1_d;
    al_c        = {shifted_c[AL_W-1:1], shifted_c[0] | (|(small_ext_c & mask_c))};
    if (s1_d >= D_W'(AL_W)) al_c = AL_W'(1);
  end

  // S3: magnitude add or subtract with carry bit
  logic [SUM_W-1:0] big_ext_c, sum_c;

  always_comb begin
    big_ext_c = {1'b0, s2_big_frac, GRS_W'(0)};
    sum_c     = s2_eff_sub ? (big_ext_c - {1'b0, s2_al}) : (big_ext_c + {1'b0, s2_al});
  end

  // S4: carry and leading zeros share one left shift; exp moves by 1 - lz
  logic [LZ_W-1:0]  lz_c;
  logic             zero_c;
  logic [SUM_W-1:0] norm_c;
  logic [AL_W-1:0]  mant_c;
  logic [E_W-1:0]   norm_exp_c;

  fadd_lzc #(.W(SUM_W), .CW(LZ_W)) u_lzc (
    .x      (s3_sum),
    .lz_c   (lz_c),
    .zero_c (zero_c)
  );

  always_comb begin
    norm_c     = s3_sum << lz_c;
    mant_c     = {norm_c[SUM_W-1:2], |norm_c[1:0]};
    norm_exp_c = s3_exp + E_W'(1) - E_W'(lz_c);
  end

  // S5: round to nearest even
  logic [M_W-1:0] trunc_c, res_frac_c;
  logic [M_W:0]   rsum_c;
  logic           round_up_c;
  logic [E_W-1:0] res_exp_c;

  always_comb begin
    trunc_c    = s4_mant[AL_W-1:GRS_W];
    round_up_c = s4_mant[2] & (s4_mant[1] | s4_mant[0] | trunc_c[0]);
    rsum_c     = {1'b0, trunc_c} + (M_W + 1)'(round_up_c);
    res_frac_c = rsum_c[M_W-1:0];
    res_exp_c  = s4_exp;
    if (rsum_c[M_W]) begin
      res_frac_c = rsum_c[M_W:1];
      res_exp_c  = s4_exp + E_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
      s3_v <= 1'b0;
      s4_v <= 1'b0;
    end else begin
      s1_v <= in_valid;
      s2_v <= s1_v;
      s3_v <= s2_v;
      s4_v <= s3_v;
    end
  end

  always_ff @(posedge clk) begin
    s1_sign       <= sign_c;
    s1_eff_sub    <= eff_sub_c;
    s1_exp        <= big_exp_c;
    s1_big_frac   <= big_frac_c;
    s1_small_frac <= small_frac_c;
    s1_d          <= d_c;
    s2_sign       <= s1_sign;
    s2_eff_sub    <= s1_eff_sub;
    s2_exp        <= s1_exp;
    s2_big_frac   <= s1_big_frac;
    s2_al         <= al_c;
    s3_sign       <= s2_sign;
    s3_exp        <= s2_exp;
    s3_sum        <= sum_c;
    s4_sign       <= s3_sign;
    s4_exp        <= norm_exp_c;
    s4_mant       <= mant_c;
    s4_zero       <= zero_c;
  end

  // c holds its last value while out_valid is low
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      c         <= '0;
`ifdef FADD_ZERO_FLAG_EN
      c_zero    <= 1'b0;
`endif
    end else begin
      out_valid <= s4_v;
      if (s4_v) c <= s4_zero ? '0 : {s4_sign, res_exp_c, res_frac_c};
`ifdef FADD_ZERO_FLAG_EN
      c_zero    <= s4_v & s4_zero;
`endif
    end
  end

endmodule

// File: tb/tb_fadd.sv
// Self-checking bench for fadd: directed cases plus random ops vs exact-arithmetic model.
module tb_fadd;
  import fadd_pkg::*;

  logic   clk = 1'b0;
  logic   rst, in_valid, sub, out_valid;
  p_float a, b, c;
`ifdef FADD_ZERO_FLAG_EN
  logic   c_zero;
`endif

  always #5 clk = ~clk;

  fadd dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
`ifdef FADD_ZERO_FLAG_EN
    .c_zero    (c_zero),
`endif
    .c         (c)
  );

  typedef struct packed {
    logic   v;
    p_float c;
  } exp_t;

  exp_t   pipe_q[$];
  string  tag_q[$];
  p_float last_c;
  int     n_pass = 0;
  int     n_total = 0;

  function automatic p_float mk(input logic s, input logic [E_W-1:0] e, input logic [M_W-1:0] f);
    p_float r;
    r.sign = s;
    r.exp  = e;
    r.frac = f;
    return r;
  endfunction

  // Exact sum on a common integer scale, then round to nearest even
  function automatic p_float ref_add(input p_float x, input p_float y, input logic s);
    int     ex, ey, emin, p, sh, er;
    longint mx, my, sum, mag, q, rem, half;
    p_float r;
    ex   = int'($signed(x.exp));
    ey   = int'($signed(y.exp));
    emin = (ex < ey) ? ex : ey;
    mx   = longint'(x.frac) << (ex - emin);
    my   = longint'(y.frac) << (ey - emin);
    sum  = (x.sign ? -mx : mx) + ((y.sign ^ s) ? -my : my);
    r    = '0;
    if (sum == 0) return r;
    mag = (sum < 0) ? -sum : sum;
    p = 0;
    for (int i = 0; i < 63; i++) if (mag[i]) p = i;
    if (p > FRAC_W) begin
      sh   = p - FRAC_W;
      q    = mag >> sh;
      rem  = mag - (q << sh);
      half = longint'(1) << (sh - 1);
      if ((rem > half) || ((rem == half) && q[0])) q++;
      er = emin + sh;
      if (q == longint'(1) << M_W) begin
        q  = q >> 1;
        er = er + 1;
      end
    end else begin
      q  = mag << (FRAC_W - p);
      er = emin + p - FRAC_W;
    end
    r.sign = (sum < 0);
    r.exp  = E_W'(er);
    r.frac = M_W'(q);
    return r;
  endfunction

  function automatic p_float rand_float();
    int e;
    e = int'($urandom_range(40, 0)) - 20;
    return mk(1'($urandom_range(1, 0)), E_W'(e), M_W'(12'h800 | 12'($urandom_range(2047, 0))));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_total++;
    assert (obs === want) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, want);
  endtask

  // One clock: drive, let the edge sample, then compare what leaves the pipe
  task automatic step(input logic r, input logic iv, input p_float ia, input p_float ib,
                      input logic is, input logic use_w, input p_float w, input string tag);
    exp_t  e, o;
    string ot;
    rst = r; in_valid = iv; a = ia; b = ib; sub = is;
    @(posedge clk);
    #1;
    e.v = iv && !r;
    e.c = use_w ? w : ref_add(ia, ib, is);
    if (r) begin
      foreach (pipe_q[i]) pipe_q[i].v = 1'b0;
    end
    pipe_q.push_back(e);
    tag_q.push_back(tag);
    o  = pipe_q.pop_front();
    ot = tag_q.pop_front();
    if (r) last_c = '0;
    else if (o.v) last_c = o.c;
    chk({ot, " out_valid"}, 32'(out_valid), 32'(o.v));
    chk({ot, " c"}, 32'(c), 32'(last_c));
`ifdef FADD_ZERO_FLAG_EN
    chk({ot, " c_zero"}, 32'(c_zero), 32'(o.v && (o.c == '0)));
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, mk(0, 0, 12'h800), mk(0, 0, 12'h800), 1'b0, 1'b0, '0, "idle");
  endtask

  p_float one, x, y;
  logic   s;

  initial begin
    one    = mk(1'b0, 9'h000, 12'h800);
    last_c = '0;
    for (int i = 0; i < FADD_LAT - 1; i++) begin
      pipe_q.push_back('0);
      tag_q.push_back("pre");
    end

    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, one, one, 1'b0, 1'b0, '0, "reset");

    // Directed cases with hand-derived results
    step(0, 1, mk(0, 9'h000, 12'hC00), mk(0, 9'h000, 12'hC00), 0, 1, mk(0, 9'h001, 12'hC00), "1.5+1.5");
    step(0, 1, one, one, 1, 1, '0, "1.0-1.0");
    step(0, 1, one, mk(0, 9'h1F4, 12'h800), 0, 1, one, "tie_even");
    // 1 + 0.75 ulp rounds up by one ulp
    step(0, 1, one, mk(0, 9'h1F4, 12'hC00), 0, 1, mk(0, 9'h000, 12'h801), "above_half");
    step(0, 1, one, mk(0, 9'h1FF, 12'hFFF), 1, 1, mk(0, 9'h1F4, 12'h800), "cancel");
    step(0, 1, mk(0, 9'h028, 12'h800), mk(1, 9'h000, 12'hFFF), 0, 1, mk(0, 9'h028, 12'h800), "shift40");
    step(0, 1, mk(1, 9'h003, 12'hA00), mk(1, 9'h003, 12'hA00), 1, 1, '0, "neg_zero");
    step(0, 1, mk(0, 9'h1FE, 12'h900), mk(0, 9'h002, 12'h900), 1, 1, mk(1, 9'h002, 12'h870), "b_big_sub");
    idle(FADD_LAT);

    // Valid gaps 1,0,1,1,1 must reappear unchanged
    step(0, 1, rand_float(), rand_float(), 0, 0, '0, "gap0");
    step(0, 0, one, one, 0, 0, '0, "gap1");
    for (int i = 0; i < 3; i++) step(0, 1, rand_float(), rand_float(), 1, 0, '0, "gapN");
    idle(FADD_LAT);

    // Reset after the third input discards everything in flight
    for (int i = 0; i < 3; i++) step(0, 1, rand_float(), rand_float(), 0, 0, '0, "pre_rst");
    step(1, 1, rand_float(), rand_float(), 0, 0, '0, "mid_rst");
    idle(FADD_LAT + 1);

    // Random operands, biased towards cancellation in a third of cases
    for (int i = 0; i < 400; i++) begin
      x = rand_float();
      y = rand_float();
      s = 1'($urandom_range(1, 0));
      if ($urandom_range(2, 0) == 0) begin
        y.exp  = x.exp + E_W'(int'($urandom_range(2, 0)) - 1);
        y.frac = x.frac ^ M_W'($urandom_range(15, 0));
        s      = ~(x.sign ^ y.sign);
      end
      step((i == 200), ($urandom_range(3, 0) != 0), x, y, s, 0, '0, "rand");
    end
    idle(FADD_LAT + 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
